// File: rtl/parity_serial_pkg.sv
// Shared types and helpers for the serial mux-built parity engine.
package parity_serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    function automatic int calc_n(int width, int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

endpackage

// File: rtl/xor_cell.sv
// Two-input XOR built only from 2:1 mux cells: one mux acts as an inverter on b,
// the second selects b or ~b depending on a.
module xor_cell (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);

    logic bInv;

    assign bInv = b_i ? 1'b0 : 1'b1;
    assign y_o  = a_i ? bInv : b_i;

endmodule

// File: rtl/parity_serial_mux.sv
// Folds a WIDTH-bit word into one parity bit, CHUNK bits per clock, with
// valid/ready handshakes on both sides and an XOR datapath made of mux cells.
module parity_serial_mux
    import parity_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             odd_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic             busy
);

    localparam int N     = calc_n(WIDTH, CHUNK);
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("parity_serial_mux: WIDTH must be a non-zero multiple of CHUNK");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CHUNK-1:0] chain;
    logic             accFold;

    // Chunk reduction as a ripple chain of CHUNK-1 cells, then one cell folds into acc.
    assign chain[0] = shreg_q[0];
    for (genvar i = 1; i < CHUNK; i++) begin : g_tree
        xor_cell u_xor (
            .a_i (chain[i-1]),
            .b_i (shreg_q[i]),
            .y_o (chain[i])
        );
    end

    xor_cell u_fold (
        .a_i (acc_q),
        .b_i (chain[CHUNK-1]),
        .y_o (accFold)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    acc_d   = odd_mode;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = accFold;
                shreg_d = shreg_q >> CHUNK;
                // cnt saturates at the last chunk so it never wraps.
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_parity = acc_q;
    assign busy       = (state_q != IDLE);

    a_parity_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> $stable(out_parity));

    a_ready_idle: assert property (@(posedge clk) disable iff (rst)
        in_ready == (state_q == IDLE));

endmodule

// File: tb/tb_parity_serial_mux.sv
// Directed and random checks of parity_serial_mux across three geometries,
// with a queue of expected parities filled on accept and drained on output.
module tb_parity_serial_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  inValid;
    logic [2:0]  oddMode;
    logic [2:0]  outReady;
    logic [2:0]  inReady;
    logic [2:0]  outValid;
    logic [2:0]  outParity;
    logic [2:0]  busy;
    logic [31:0] inData [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit expQ[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: WIDTH=8 CHUNK=2 (N=4); 1: WIDTH=CHUNK=8 (N=1); 2: WIDTH=32 CHUNK=1 (N=32).
    parity_serial_mux #(.WIDTH(8), .CHUNK(2)) dutA (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
        .in_data(inData[0][7:0]), .odd_mode(oddMode[0]), .out_valid(outValid[0]),
        .out_ready(outReady[0]), .out_parity(outParity[0]), .busy(busy[0])
    );

    parity_serial_mux #(.WIDTH(8), .CHUNK(8)) dutB (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
        .in_data(inData[1][7:0]), .odd_mode(oddMode[1]), .out_valid(outValid[1]),
        .out_ready(outReady[1]), .out_parity(outParity[1]), .busy(busy[1])
    );

    parity_serial_mux #(.WIDTH(32), .CHUNK(1)) dutC (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
        .in_data(inData[2]), .odd_mode(oddMode[2]), .out_valid(outValid[2]),
        .out_ready(outReady[2]), .out_parity(outParity[2]), .busy(busy[2])
    );

    function automatic logic [31:0] maskOf(int k);
        return (k == 2) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    function automatic int latOf(int k);
        if (k == 0) return 4;
        if (k == 1) return 1;
        return 32;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] expVal);
        total++;
        assert (obs === expVal) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expVal);
        end
    endtask

    // Presents a word, waits for the accept edge, and queues the reference parity.
    // hold keeps in_valid high afterwards with scrambled data/odd_mode.
    task automatic applyStimulus(int k, logic [31:0] data, logic odd, logic hold,
                                 output int acceptCyc);
        int n;
        n = 0;
        inValid[k] = 1'b1;
        inData[k]  = data;
        oddMode[k] = odd;
        while (!inReady[k] && n < 200) begin
            tick();
            n++;
        end
        checkOutput("accept_ready", {31'd0, inReady[k]}, 32'd1);
        tick();
        acceptCyc = cyc;
        expQ.push_back((^(data & maskOf(k))) ^ odd);
        inData[k]  = ~data;
        oddMode[k] = ~odd;
        if (!hold) inValid[k] = 1'b0;
    endtask

    task automatic waitOutput(int k, int acceptCyc, logic handshake);
        int n;
        bit expBit;
        n = 0;
        expBit = 1'b0;
        while (!outValid[k] && n < 200) begin
            tick();
            n++;
        end
        checkOutput("out_valid_seen", {31'd0, outValid[k]}, 32'd1);
        checkOutput("latency", cyc - acceptCyc, latOf(k));
        if (expQ.size() > 0) begin
            expBit = expQ.pop_front();
        end
        checkOutput("parity", {31'd0, outParity[k]}, {31'd0, expBit});
        if (handshake) begin
            outReady[k] = 1'b1;
            tick();
        end
    endtask

    initial begin
        int c0;
        int c1;
        logic [31:0] rnd;
        logic        rOdd;

        rst      = 1'b1;
        inValid  = '0;
        oddMode  = '0;
        outReady = '0;
        for (int k = 0; k < 3; k++) inData[k] = '0;

        // Reset state, including in_valid being ignored while reset is held.
        tick();
        inValid[0] = 1'b1;
        inData[0]  = 32'h55;
        tick();
        for (int k = 0; k < 3; k++) begin
            checkOutput("rst_out_valid", {31'd0, outValid[k]}, 32'd0);
            checkOutput("rst_out_parity", {31'd0, outParity[k]}, 32'd0);
            checkOutput("rst_busy", {31'd0, busy[k]}, 32'd0);
        end
        inValid[0] = 1'b0;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("post_rst_in_ready", {31'd0, inReady[k]}, 32'd1);
        end

        // Basic even/odd parity on 0xA5.
        $display("[TB] basic parity, WIDTH=8 CHUNK=2");
        outReady = 3'b111;
        applyStimulus(0, 32'hA5, 1'b0, 1'b0, c0);
        waitOutput(0, c0, 1'b1);
        applyStimulus(0, 32'hA5, 1'b1, 1'b0, c0);
        waitOutput(0, c0, 1'b1);

        // Backpressure: result and flags must hold while out_ready is low.
        $display("[TB] backpressure");
        outReady[0] = 1'b0;
        applyStimulus(0, 32'h07, 1'b0, 1'b0, c0);
        waitOutput(0, c0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", {31'd0, outValid[0]}, 32'd1);
            checkOutput("bp_parity", {31'd0, outParity[0]}, 32'd1);
            checkOutput("bp_in_ready", {31'd0, inReady[0]}, 32'd0);
            checkOutput("bp_busy", {31'd0, busy[0]}, 32'd1);
            tick();
        end
        outReady[0] = 1'b1;
        tick();
        checkOutput("bp_idle_in_ready", {31'd0, inReady[0]}, 32'd1);
        checkOutput("bp_idle_busy", {31'd0, busy[0]}, 32'd0);
        checkOutput("bp_idle_out_valid", {31'd0, outValid[0]}, 32'd0);

        // Back-to-back words with in_valid held: accepts must be N+2 apart.
        $display("[TB] back-to-back");
        applyStimulus(0, 32'h01, 1'b0, 1'b1, c0);
        waitOutput(0, c0, 1'b1);
        applyStimulus(0, 32'hFF, 1'b0, 1'b1, c1);
        checkOutput("b2b_spacing_1", c1 - c0, 32'd6);
        waitOutput(0, c1, 1'b1);
        applyStimulus(0, 32'h80, 1'b0, 1'b0, c0);
        checkOutput("b2b_spacing_2", c0 - c1, 32'd6);
        waitOutput(0, c0, 1'b1);

        // Reset during SHIFT abandons the word; next word behaves normally.
        $display("[TB] reset mid-shift");
        applyStimulus(0, 32'h01, 1'b0, 1'b0, c0);
        tick();
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", {31'd0, outValid[0]}, 32'd0);
        checkOutput("midrst_busy", {31'd0, busy[0]}, 32'd0);
        expQ.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("midrst_no_output", {31'd0, outValid[0]}, 32'd0);
            tick();
        end
        applyStimulus(0, 32'h03, 1'b0, 1'b0, c0);
        waitOutput(0, c0, 1'b1);

        // Single-chunk geometry: result one cycle after accept.
        $display("[TB] WIDTH=CHUNK=8");
        applyStimulus(1, 32'h80, 1'b0, 1'b0, c0);
        waitOutput(1, c0, 1'b1);
        applyStimulus(1, 32'h81, 1'b1, 1'b0, c0);
        waitOutput(1, c0, 1'b1);
        applyStimulus(1, 32'hFF, 1'b0, 1'b0, c0);
        waitOutput(1, c0, 1'b1);

        // Bit-serial geometry against a reduction-XOR reference.
        $display("[TB] WIDTH=32 CHUNK=1 random words");
        for (int i = 0; i < 1000; i++) begin
            rnd  = $urandom;
            rOdd = 1'($urandom_range(0, 1));
            applyStimulus(2, rnd, rOdd, 1'b0, c0);
            waitOutput(2, c0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
